// File: rtl/sine_dac_spi.sv
// Streams each sampled 10-bit sine value to an SPI DAC as a 16-bit mode-0 frame,
// with an Avalon-MM slave for enable, SCLK divider and status. Optional LDAC strobe: SINE_DAC_LDAC_EN.
module sine_dac_spi #(
    parameter logic [3:0]  CMD_BITS    = 4'b0011,
    parameter logic [15:0] DEFAULT_DIV = 16'd4,
    parameter int          CS_GAP      = 2
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic        ChipSelect,
    input  logic        Write,
    input  logic        Read,
    input  logic [1:0]  Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [9:0]  iData_sin,
    output logic        oSCLK,
    output logic        oMOSI,
    output logic        oCS_n
`ifdef SINE_DAC_LDAC_EN
    ,output logic       oLDAC_n
`endif
);

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT, GAP
`ifdef SINE_DAC_LDAC_EN
        , LDAC
`endif
    } state_t;

    state_t      state_q;
    logic        en_q;
    logic [15:0] div_reg_q;
    logic [15:0] div_q;
    logic [15:0] hp_q;
    logic [5:0]  hcnt_q;
    logic [15:0] shreg_q;
    logic        sclk_q;
    logic        mosi_q;
    logic        cs_n_q;
    logic [15:0] cnt_q;
    logic [31:0] rdata_q;

    logic tick, gap_entry, wr, rd, clr, busy;
    logic unused_wdata;

    assign tick      = (hp_q == div_q);
    assign gap_entry = (state_q == SHIFT) && tick && (hcnt_q == 6'd31);
    assign wr        = ChipSelect & Write;
    assign rd        = ChipSelect & Read;
    assign clr       = wr && (Address == 2'd0) && WriteData[1];
    assign busy      = (state_q != IDLE);
    assign unused_wdata = ^WriteData[31:16];

    assign oSCLK    = sclk_q;
    assign oMOSI    = mosi_q;
    assign oCS_n    = cs_n_q;
    assign ReadData = rdata_q;

`ifdef SINE_DAC_LDAC_EN
    logic ldac_n_q;
    assign oLDAC_n = ldac_n_q;
`endif

    // Frame sequencer; hp_q counts Clk cycles within one SCLK half-period.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            div_q   <= DEFAULT_DIV;
            hp_q    <= '0;
            hcnt_q  <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
`ifdef SINE_DAC_LDAC_EN
            ldac_n_q <= 1'b1;
`endif
        end else begin
            if (state_q == IDLE || tick) hp_q <= '0;
            else                         hp_q <= hp_q + 16'd1;

            case (state_q)
                IDLE: if (en_q) begin
                    shreg_q <= {CMD_BITS, iData_sin, 2'b00};
                    div_q   <= div_reg_q;
                    cs_n_q  <= 1'b0;
                    mosi_q  <= CMD_BITS[3];
                    hcnt_q  <= '0;
                    state_q <= SETUP;
                end
                SETUP: if (tick) begin
                    sclk_q  <= 1'b1;
                    hcnt_q  <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: if (tick) begin
                    if (hcnt_q == 6'd31) begin
                        cs_n_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        hcnt_q  <= '0;
                        state_q <= GAP;
                    end else begin
                        hcnt_q <= hcnt_q + 6'd1;
                        sclk_q <= ~sclk_q;
                        // Data moves on the falling edge so it is stable at the next rise.
                        if (sclk_q) begin
                            shreg_q <= {shreg_q[14:0], 1'b0};
                            mosi_q  <= shreg_q[14];
                        end
                    end
                end
                GAP: if (tick) begin
                    if (hcnt_q == 6'(CS_GAP - 1)) begin
`ifdef SINE_DAC_LDAC_EN
                        ldac_n_q <= 1'b0;
                        state_q  <= LDAC;
`else
                        state_q  <= IDLE;
`endif
                    end else begin
                        hcnt_q <= hcnt_q + 6'd1;
                    end
                end
`ifdef SINE_DAC_LDAC_EN
                LDAC: if (tick) begin
                    ldac_n_q <= 1'b1;
                    state_q  <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    // Avalon register file and frame counter.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            en_q      <= 1'b0;
            div_reg_q <= DEFAULT_DIV;
            cnt_q     <= '0;
            rdata_q   <= '0;
        end else begin
            if (wr && Address == 2'd0) en_q      <= WriteData[0];
            if (wr && Address == 2'd1) div_reg_q <= WriteData[15:0];
            if (clr)            cnt_q <= '0;
            else if (gap_entry) cnt_q <= cnt_q + 16'd1;
            if (rd) begin
                case (Address)
                    2'd0:    rdata_q <= {31'b0, en_q};
                    2'd1:    rdata_q <= {16'b0, div_reg_q};
                    2'd2:    rdata_q <= {15'b0, busy, cnt_q};
                    default: rdata_q <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sine_dac_spi.sv
// Self-checking bench for sine_dac_spi: decodes the SPI stream from the pins and compares
// frame content, timing and counters with values derived from the frame/period rules.
module tb_sine_dac_spi;

    localparam int CS_GAP = 2;
`ifdef SINE_DAC_LDAC_EN
    localparam int LD = 1;
`else
    localparam int LD = 0;
`endif
    localparam time PER = 10;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic        ChipSelect = 1'b0, Write = 1'b0, Read = 1'b0;
    logic [1:0]  Address = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic [9:0]  iData_sin = '0;
    logic        oSCLK, oMOSI, oCS_n;
`ifdef SINE_DAC_LDAC_EN
    logic        oLDAC_n;
`endif

    sine_dac_spi dut (
        .Clk(Clk), .ResetN(ResetN), .ChipSelect(ChipSelect), .Write(Write), .Read(Read),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .iData_sin(iData_sin),
        .oSCLK(oSCLK), .oMOSI(oMOSI), .oCS_n(oCS_n)
`ifdef SINE_DAC_LDAC_EN
        , .oLDAC_n(oLDAC_n)
`endif
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    // Pin-level SPI decoder
    time         fall_t[$];
    time         rise_t[$];
    logic [15:0] cap_bits[$];
    int          cap_rises[$];
    logic [15:0] sh = '0;
    int          rises = 0;

    always @(posedge oSCLK) begin sh = {sh[14:0], oMOSI}; rises++; end
    always @(negedge oCS_n) begin fall_t.push_back($time); sh = '0; rises = 0; end
    always @(posedge oCS_n) if (ResetN === 1'b1) begin
        rise_t.push_back($time); cap_bits.push_back(sh); cap_rises.push_back(rises);
    end

`ifdef SINE_DAC_LDAC_EN
    int ldac_cnt = 0, ldac_bad = 0;
    always @(negedge oLDAC_n) if (ResetN === 1'b1) begin
        ldac_cnt++;
        if (oCS_n !== 1'b1) ldac_bad++;
    end
`endif

    function automatic logic [15:0] frame_of(input logic [9:0] d);
        return {4'b0011, d, 2'b00};
    endfunction

    function automatic time period_of(input int d);
        return (1 + (33 + CS_GAP + LD) * (d + 1)) * PER;
    endfunction

    task automatic mon_clear();
        fall_t.delete(); rise_t.delete(); cap_bits.delete(); cap_rises.delete();
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge Clk);
        ChipSelect = 1'b1; Write = 1'b1; Address = a; WriteData = d;
        @(negedge Clk);
        ChipSelect = 1'b0; Write = 1'b0; WriteData = '0;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge Clk);
        ChipSelect = 1'b1; Read = 1'b1; Address = a;
        @(negedge Clk);
        ChipSelect = 1'b0; Read = 1'b0;
        d = ReadData;
    endtask

    task automatic wait_falls(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (fall_t.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rises(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (rise_t.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        @(negedge Clk);
        n_checks++; if (oCS_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n got %b want 1", oCS_n); end
        n_checks++; if (oSCLK !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b want 0", oSCLK); end
        n_checks++; if (oMOSI !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got %b want 0", oMOSI); end
        n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got %h want 0", ReadData); end
        @(negedge Clk); ResetN = 1'b1;
        av_read(2'd2, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_status got %h want 0", rd); end
        av_read(2'd1, rd);
        n_checks++; if (rd !== 32'd4) begin n_fail++; $display("FAIL reset_div got %h want 4", rd); end
        av_read(2'd0, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", rd); end
        av_read(2'd3, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got %h want 0", rd); end
    endtask

    task automatic test_frame_content();
        bit ok;
        mon_clear();
        av_write(2'd1, 32'd0);
        iData_sin = 10'h2AA;
        av_write(2'd0, 32'd1);
        wait_falls(1, 500, ok);
        iData_sin = 10'h3FF;
        wait_falls(2, 500, ok);
        av_write(2'd0, 32'd0);
        wait_rises(2, 500, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL frame_timeout got %0d frames want 2", rise_t.size()); end
        else begin
            exp_cnt += 2;
            n_checks++; if (cap_bits[0] !== 16'h3AA8) begin n_fail++; $display("FAIL frame0_bits got %h want 3aa8", cap_bits[0]); end
            n_checks++; if (cap_bits[1] !== 16'h3FFC) begin n_fail++; $display("FAIL frame1_bits got %h want 3ffc", cap_bits[1]); end
            n_checks++; if (cap_rises[0] !== 16) begin n_fail++; $display("FAIL frame0_rises got %0d want 16", cap_rises[0]); end
            n_checks++; if (fall_t[1] - fall_t[0] !== period_of(0)) begin n_fail++; $display("FAIL frame_period_div0 got %0t want %0t", fall_t[1] - fall_t[0], period_of(0)); end
        end
        repeat (60) @(negedge Clk);
    endtask

    task automatic test_timing();
        bit ok;
        int divs[2];
        divs[0] = 4;
        divs[1] = int'($urandom_range(1, 6));
        foreach (divs[k]) begin
            mon_clear();
            av_write(2'd1, 32'(divs[k]));
            av_write(2'd0, 32'd1);
            wait_falls(2, 3000, ok);
            av_write(2'd0, 32'd0);
            wait_rises(2, 3000, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL timing_timeout div %0d got %0d frames", divs[k], rise_t.size()); end
            else begin
                exp_cnt += 2;
                n_checks++; if (fall_t[1] - fall_t[0] !== period_of(divs[k])) begin n_fail++; $display("FAIL timing_period div %0d got %0t want %0t", divs[k], fall_t[1] - fall_t[0], period_of(divs[k])); end
                n_checks++; if (rise_t[0] - fall_t[0] !== 33 * (divs[k] + 1) * PER) begin n_fail++; $display("FAIL timing_cs_low div %0d got %0t want %0t", divs[k], rise_t[0] - fall_t[0], 33 * (divs[k] + 1) * PER); end
                n_checks++; if (cap_rises[1] !== 16) begin n_fail++; $display("FAIL timing_rises div %0d got %0d want 16", divs[k], cap_rises[1]); end
            end
            repeat (50 * (divs[k] + 1)) @(negedge Clk);
        end
    endtask

    task automatic test_disable_midframe();
        bit ok;
        logic [31:0] rd;
        mon_clear();
        av_write(2'd1, 32'd1);
        iData_sin = 10'($urandom);
        av_write(2'd0, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge Clk);
            if (fall_t.size() >= 1 && rises >= 5) begin ok = 1'b1; break; end
        end
        av_write(2'd0, 32'd0);
        av_write(2'd1, 32'd9);
        wait_rises(1, 500, ok);
        repeat (400) @(negedge Clk);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL disable_timeout got %0d frames want 1", rise_t.size()); end
        else begin
            exp_cnt += 1;
            n_checks++; if (cap_rises[0] !== 16) begin n_fail++; $display("FAIL disable_rises got %0d want 16", cap_rises[0]); end
            n_checks++; if (rise_t[0] - fall_t[0] !== 33 * 2 * PER) begin n_fail++; $display("FAIL disable_div_change got %0t want %0t", rise_t[0] - fall_t[0], 33 * 2 * PER); end
        end
        n_checks++; if (fall_t.size() !== 1) begin n_fail++; $display("FAIL disable_no_restart got %0d frames want 1", fall_t.size()); end
        n_checks++; if (oCS_n !== 1'b1) begin n_fail++; $display("FAIL disable_cs_idle got %b want 1", oCS_n); end
        av_read(2'd2, rd);
        n_checks++; if (rd !== {15'b0, 1'b0, 16'(exp_cnt)}) begin n_fail++; $display("FAIL disable_status got %h want %h", rd, {15'b0, 1'b0, 16'(exp_cnt)}); end
        av_read(2'd1, rd);
        n_checks++; if (rd !== 32'd9) begin n_fail++; $display("FAIL div_readback got %h want 9", rd); end
    endtask

    task automatic test_counter();
        bit ok;
        logic [31:0] rd;
        mon_clear();
        av_write(2'd0, 32'd2);
        exp_cnt = 0;
        av_write(2'd1, 32'd0);
        av_write(2'd0, 32'd1);
        wait_falls(1, 500, ok);
        av_read(2'd2, rd);
        n_checks++; if (rd[16] !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame got %b want 1", rd[16]); end
        wait_falls(3, 500, ok);
        av_write(2'd0, 32'd0);
        wait_rises(3, 500, ok);
        repeat (50) @(negedge Clk);
        av_read(2'd2, rd);
        n_checks++; if (rd !== 32'd3) begin n_fail++; $display("FAIL count_three got %h want 3", rd); end
        av_write(2'd0, 32'd1);
        wait_falls(4, 500, ok);
        av_write(2'd0, 32'd3);
        av_read(2'd2, rd);
        n_checks++; if (rd[15:0] !== 16'd0) begin n_fail++; $display("FAIL count_clear got %h want 0", rd[15:0]); end
        av_read(2'd0, rd);
        n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL clear_keeps_enable got %h want 1", rd); end
        // Line the clear up with the posedge that enters GAP (33 cycles after CS_n falls at DIV=0).
        wait_falls(5, 500, ok);
        repeat (31) @(negedge Clk);
        av_write(2'd0, 32'd2);
        repeat (80) @(negedge Clk);
        exp_cnt = 0;
        av_read(2'd2, rd);
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL clear_vs_increment got %h want 0", rd); end
        n_checks++; if (fall_t.size() !== 5) begin n_fail++; $display("FAIL counter_frames got %0d want 5", fall_t.size()); end
    endtask

    task automatic test_random_frames();
        bit ok;
        logic [31:0] rd;
        logic [9:0] exp_d[6];
        int exp_div[6];
        int pend_div;
`ifdef SINE_DAC_LDAC_EN
        int ldac0;
        ldac0 = ldac_cnt;
`endif
        mon_clear();
        pend_div = int'($urandom_range(0, 3));
        av_write(2'd1, 32'(pend_div));
        iData_sin = 10'($urandom);
        av_write(2'd0, 32'd1);
        for (int f = 0; f < 6; f++) begin
            wait_falls(f + 1, 2000, ok);
            exp_d[f]   = iData_sin;
            exp_div[f] = pend_div;
            iData_sin  = 10'($urandom);
            if (f == 5) av_write(2'd0, 32'd0);
            else begin
                pend_div = int'($urandom_range(0, 3));
                av_write(2'd1, 32'(pend_div));
            end
        end
        wait_rises(6, 2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL random_timeout got %0d frames want 6", rise_t.size()); end
        else begin
            exp_cnt += 6;
            for (int f = 0; f < 6; f++) begin
                n_checks++; if (cap_bits[f] !== frame_of(exp_d[f])) begin n_fail++; $display("FAIL random_bits frame %0d got %h want %h", f, cap_bits[f], frame_of(exp_d[f])); end
                n_checks++; if (rise_t[f] - fall_t[f] !== 33 * (exp_div[f] + 1) * PER) begin n_fail++; $display("FAIL random_cs_low frame %0d got %0t want %0t", f, rise_t[f] - fall_t[f], 33 * (exp_div[f] + 1) * PER); end
                if (f > 0) begin
                    n_checks++; if (fall_t[f] - fall_t[f-1] !== period_of(exp_div[f-1])) begin n_fail++; $display("FAIL random_period frame %0d got %0t want %0t", f, fall_t[f] - fall_t[f-1], period_of(exp_div[f-1])); end
                end
            end
        end
        repeat (200) @(negedge Clk);
        av_read(2'd2, rd);
        n_checks++; if (rd !== {16'b0, 16'(exp_cnt)}) begin n_fail++; $display("FAIL random_status got %h want %h", rd, {16'b0, 16'(exp_cnt)}); end
`ifdef SINE_DAC_LDAC_EN
        n_checks++; if (ldac_cnt - ldac0 !== 6) begin n_fail++; $display("FAIL ldac_pulses got %0d want 6", ldac_cnt - ldac0); end
        n_checks++; if (ldac_bad !== 0) begin n_fail++; $display("FAIL ldac_while_cs_low got %0d want 0", ldac_bad); end
`endif
    endtask

    task automatic test_reset_midframe();
        bit ok;
        logic [31:0] rd;
        int nf;
        mon_clear();
        av_write(2'd1, 32'd2);
        av_write(2'd0, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            if (fall_t.size() >= 1 && rises >= 8) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midreset_timeout got %0d rises want 8", rises); end
        n_checks++; if (oCS_n !== 1'b0) begin n_fail++; $display("FAIL midreset_in_frame got %b want 0", oCS_n); end
        #2 ResetN = 1'b0;
        #1;
        n_checks++; if (oCS_n !== 1'b1) begin n_fail++; $display("FAIL midreset_cs_n got %b want 1", oCS_n); end
        n_checks++; if (oSCLK !== 1'b0) begin n_fail++; $display("FAIL midreset_sclk got %b want 0", oSCLK); end
        @(negedge Clk); ResetN = 1'b1;
        exp_cnt = 0;
        nf = fall_t.size();
        av_read(2'd2, rd);
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL midreset_status got %h want 0", rd); end
        repeat (300) @(negedge Clk);
        n_checks++; if (fall_t.size() !== nf) begin n_fail++; $display("FAIL midreset_no_restart got %0d want %0d", fall_t.size(), nf); end
    endtask

    initial begin
        test_reset();
        test_frame_content();
        test_timing();
        test_disable_midframe();
        test_counter();
        test_random_frames();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
